wb_rr_arbiter: RTL and testbench

//  Round-robin arbiter sharing one Wishbone slave port among NM masters (CPU ibus/dbus, future DMA).

---
 rtl/wb_arb_pkg.sv | 27 ++
 rtl/wb_rr_arbiter_rr_pick.sv | 32 +++
 rtl/wb_rr_arbiter.sv | 159 +++++++++++++++
 tb/tb_wb_rr_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the Wishbone round-robin arbiter.
// Holds the FSM encoding, Wishbone bus widths and cycle-type codes.
// Also holds the cyclic index helper used by the round-robin picker.
package wb_arb_pkg;

  localparam int WB_AW  = 32;
  localparam int WB_DW  = 32;
  localparam int WB_SW  = WB_DW / 8;
  localparam int WB_CW  = 3;
  localparam int WDOG_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_DRAIN = 2'd2
  } arb_state_t;

  localparam logic [WB_CW-1:0] CTI_CLASSIC = 3'b000;
  localparam logic [WB_CW-1:0] CTI_INCR    = 3'b010;
  localparam logic [WB_CW-1:0] CTI_EOB     = 3'b111;

  // Index 'off' positions after 'last', wrapping around n masters.
  function automatic int rr_next(input int last, input int off, input int n);
    return (last + off) % n;
  endfunction

endpackage

// File: rtl/wb_rr_arbiter_rr_pick.sv
// Round-robin picker: first requester strictly after the last owner, cyclically.
// Latency: purely combinational, result valid in the same cycle as i_req.
// Backpressure: none; the caller decides when to register the pick.
module rr_pick
  import wb_arb_pkg::*;
#(
  parameter int NM = 4,
  localparam int IW = (NM > 1) ? $clog2(NM) : 1
) (
  input  logic [NM-1:0] i_req,
  input  logic [IW-1:0] i_last,
  output logic [NM-1:0] o_gnt,
  output logic          o_vld
);

  logic [IW-1:0] w_idx;

  // Scan from last+1 around to last itself; the first hit wins.
  always_comb begin
    o_gnt = '0;
    o_vld = 1'b0;
    w_idx = '0;
    for (int off = 1; off <= NM; off++) begin
      w_idx = IW'(rr_next(int'(i_last), off, NM));
      if (!o_vld && i_req[w_idx]) begin
        o_gnt[w_idx] = 1'b1;
        o_vld        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone arbiter: NM masters share one slave, grant held per bus cycle.
// Latency: grant registered one cycle after cyc request; data/ack paths combinational.
// Backpressure: slave ack stalls the owner; watchdog errs the owner and drains a dead cycle.
module wb_rr_arbiter
  import wb_arb_pkg::*;
#(
  parameter int NM      = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic [NM*WB_AW-1:0] m_adr_i,
  input  logic [NM*WB_DW-1:0] m_dat_i,
  input  logic [NM*WB_SW-1:0] m_sel_i,
  input  logic [NM*WB_CW-1:0] m_cti_i,
  input  logic [NM-1:0]       m_we_i,
  input  logic [NM-1:0]       m_cyc_i,
  input  logic [NM-1:0]       m_stb_i,
  output logic [WB_DW-1:0]    m_dat_o,
  output logic [NM-1:0]       m_ack_o,
  output logic [NM-1:0]       m_err_o,
  output logic [WB_AW-1:0]    s_adr_o,
  output logic [WB_DW-1:0]    s_dat_o,
  output logic [WB_SW-1:0]    s_sel_o,
  output logic [WB_CW-1:0]    s_cti_o,
  output logic                s_we_o,
  output logic                s_cyc_o,
  output logic                s_stb_o,
  input  logic [WB_DW-1:0]    s_dat_i,
  input  logic                s_ack_i,
  output logic [NM-1:0]       grant_o
);

  localparam int IW = (NM > 1) ? $clog2(NM) : 1;
  localparam logic WDOG_EN = (TIMEOUT > 0);
  // Terminal count: the cycle in which a still-unacked strobe turns into err.
  localparam logic [WDOG_W-1:0] WDOG_LAST = (TIMEOUT > 0) ? WDOG_W'(TIMEOUT - 1) : '0;

  arb_state_t        r_state;
  logic [NM-1:0]     r_grant;
  logic [IW-1:0]     r_gidx;
  logic [IW-1:0]     r_last;
  logic [WDOG_W-1:0] r_wdog;

  logic [NM-1:0]     w_pick_gnt;
  logic              w_pick_vld;
  logic [IW-1:0]     w_pick_idx;
  logic              w_in_grant;
  logic              w_g_cyc;
  logic              w_g_stb;
  logic              w_timeout;

  rr_pick #(
    .NM (NM)
  ) u_pick (
    .i_req  (m_cyc_i),
    .i_last (r_last),
    .o_gnt  (w_pick_gnt),
    .o_vld  (w_pick_vld)
  );

  // Convert the one-hot pick into the index stored alongside the grant.
  always_comb begin
    w_pick_idx = '0;
    for (int k = 0; k < NM; k++) begin
      if (w_pick_gnt[k]) begin
        w_pick_idx = IW'(k);
      end
    end
  end

  assign w_in_grant = (r_state == ST_GRANT);
  assign w_g_cyc    = m_cyc_i[r_gidx];
  assign w_g_stb    = m_stb_i[r_gidx];
  // An ack in the terminal cycle takes precedence, so the err needs !s_ack_i.
  assign w_timeout  = WDOG_EN && w_in_grant && w_g_stb && !s_ack_i && (r_wdog == WDOG_LAST);

  // Arbitration FSM with grant register, last-owner pointer and watchdog counter.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      r_state <= ST_IDLE;
      r_grant <= '0;
      r_gidx  <= '0;
      r_last  <= IW'(NM - 1);
      r_wdog  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_wdog <= '0;
          if (w_pick_vld) begin
            r_grant <= w_pick_gnt;
            r_gidx  <= w_pick_idx;
            r_state <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (!w_g_cyc) begin
            // Owner ended its bus cycle: one idle cycle follows before re-arbitration.
            r_state <= ST_IDLE;
            r_last  <= r_gidx;
            r_grant <= '0;
            r_wdog  <= '0;
          end else if (w_timeout) begin
            r_state <= ST_DRAIN;
            r_wdog  <= '0;
          end else if (s_ack_i || !w_g_stb) begin
            r_wdog <= '0;
          end else if (r_wdog != '1) begin
            // Saturate rather than wrap so a huge TIMEOUT can never alias to zero.
            r_wdog <= r_wdog + 1'b1;
          end
        end
        ST_DRAIN: begin
          // Slave is cut off; keep ownership until the errored master lets go.
          r_wdog <= '0;
          if (!w_g_cyc) begin
            r_state <= ST_IDLE;
            r_last  <= r_gidx;
            r_grant <= '0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_grant <= '0;
          r_wdog  <= '0;
        end
      endcase
    end
  end

  // Route the owner's request to the slave and the slave's ack back to the owner.
  always_comb begin
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    s_cti_o = '0;
    s_we_o  = 1'b0;
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    m_ack_o = '0;
    for (int k = 0; k < NM; k++) begin
      if ((r_state != ST_IDLE) && (r_gidx == IW'(k))) begin
        s_adr_o    = m_adr_i[k*WB_AW +: WB_AW];
        s_dat_o    = m_dat_i[k*WB_DW +: WB_DW];
        s_sel_o    = m_sel_i[k*WB_SW +: WB_SW];
        s_cti_o    = m_cti_i[k*WB_CW +: WB_CW];
        s_we_o     = m_we_i[k];
        s_cyc_o    = w_in_grant & m_cyc_i[k];
        s_stb_o    = w_in_grant & m_stb_i[k];
        m_ack_o[k] = w_in_grant & s_ack_i;
      end
    end
  end

  assign m_err_o = w_timeout ? r_grant : '0;
  assign m_dat_o = s_dat_i;
  assign grant_o = r_grant;

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Self-checking bench for wb_rr_arbiter (NM=4, TIMEOUT=8).
// Inputs change 1 time unit after the rising edge; outputs are compared after that.
// Expected grant order is queued when requests are driven and popped on each grant.
module tb_wb_rr_arbiter;
  import wb_arb_pkg::*;

  localparam int NM = 4;
  localparam int TO = 8;

  logic                sys_clk;
  logic                sys_rst;
  logic [NM*WB_AW-1:0] m_adr_i;
  logic [NM*WB_DW-1:0] m_dat_i;
  logic [NM*WB_SW-1:0] m_sel_i;
  logic [NM*WB_CW-1:0] m_cti_i;
  logic [NM-1:0]       m_we_i;
  logic [NM-1:0]       m_cyc_i;
  logic [NM-1:0]       m_stb_i;
  logic [WB_DW-1:0]    m_dat_o;
  logic [NM-1:0]       m_ack_o;
  logic [NM-1:0]       m_err_o;
  logic [WB_AW-1:0]    s_adr_o;
  logic [WB_DW-1:0]    s_dat_o;
  logic [WB_SW-1:0]    s_sel_o;
  logic [WB_CW-1:0]    s_cti_o;
  logic                s_we_o;
  logic                s_cyc_o;
  logic                s_stb_o;
  logic [WB_DW-1:0]    s_dat_i;
  logic                s_ack_i;
  logic [NM-1:0]       grant_o;

  wb_rr_arbiter #(.NM(NM), .TIMEOUT(TO)) dut (
    .sys_clk (sys_clk), .sys_rst (sys_rst),
    .m_adr_i (m_adr_i), .m_dat_i (m_dat_i), .m_sel_i (m_sel_i), .m_cti_i (m_cti_i),
    .m_we_i  (m_we_i),  .m_cyc_i (m_cyc_i), .m_stb_i (m_stb_i),
    .m_dat_o (m_dat_o), .m_ack_o (m_ack_o), .m_err_o (m_err_o),
    .s_adr_o (s_adr_o), .s_dat_o (s_dat_o), .s_sel_o (s_sel_o), .s_cti_o (s_cti_o),
    .s_we_o  (s_we_o),  .s_cyc_o (s_cyc_o), .s_stb_o (s_stb_o),
    .s_dat_i (s_dat_i), .s_ack_i (s_ack_i), .grant_o (grant_o)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  typedef struct packed {
    logic [3:0]      mask;  // masters raising cyc together
    logic [2:0]      n;     // number of grants expected
    logic [3:0][1:0] ord;   // expected grant order, ord[0] first
  } vec_t;

  vec_t vt [7];
  int   exp_q [$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  function automatic logic [31:0] oh(input int k);
    return 32'(1) << k;
  endfunction

  function automatic int oh2i(input logic [NM-1:0] v);
    for (int k = 0; k < NM; k++) if (v[k]) return k;
    return 0;
  endfunction

  function automatic logic [31:0] adr_of(input int k);
    return 32'hA000_0000 + 32'(k) * 32'h10;
  endfunction

  // Wait (bounded) for a grant, pop the scoreboard and check owner and wait length.
  task automatic await_grant(input string nm, input int want_wait);
    int w;
    int e;
    w = 0;
    while (grant_o == '0 && w < 20) begin
      step();
      w++;
    end
    if (grant_o == '0) begin
      total++; bad++;
      $display("FAIL %s: no grant within 20 cycles", nm);
      return;
    end
    if (exp_q.size() == 0) begin
      total++; bad++;
      $display("FAIL %s: grant 0x%0h with nothing expected", nm, grant_o);
      return;
    end
    e = exp_q.pop_front();
    check(nm, 32'(grant_o), oh(e));
    check({nm, "_wait"}, 32'(w), 32'(want_wait));
  endtask

  // One table entry: each listed master does a single transfer, acked with cyc drop.
  task automatic run_vec(input vec_t v);
    int g;
    for (int i = 0; i < int'(v.n); i++) exp_q.push_back(int'(v.ord[i]));
    m_cyc_i = v.mask;
    m_stb_i = v.mask;
    for (int j = 0; j < int'(v.n); j++) begin
      await_grant("rr_grant", 1);
      g = oh2i(grant_o);
      check("rr_adr", s_adr_o, adr_of(g));
      s_ack_i    = 1'b1;
      s_dat_i    = 32'hD000_0000 + 32'(g);
      m_cyc_i[g] = 1'b0;
      m_stb_i[g] = 1'b0;
      #1;
      check("rr_ack", 32'(m_ack_o), oh(g));
      check("rr_dat", m_dat_o, 32'hD000_0000 + 32'(g));
      step();
      s_ack_i = 1'b0;
    end
  endtask

  initial begin
    #20000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    int first;
    int nerr;
    logic [NM-1:0] errv;

    vt[0] = '{mask: 4'b1111, n: 3'd4, ord: {2'd3, 2'd2, 2'd1, 2'd0}};
    vt[1] = '{mask: 4'b0110, n: 3'd2, ord: {2'd0, 2'd0, 2'd2, 2'd1}};
    vt[2] = '{mask: 4'b0010, n: 3'd1, ord: {2'd0, 2'd0, 2'd0, 2'd1}};
    vt[3] = '{mask: 4'b1010, n: 3'd2, ord: {2'd0, 2'd0, 2'd1, 2'd3}};
    vt[4] = '{mask: 4'b0011, n: 3'd2, ord: {2'd0, 2'd0, 2'd1, 2'd0}};
    vt[5] = '{mask: 4'b1001, n: 3'd2, ord: {2'd0, 2'd0, 2'd0, 2'd3}};
    vt[6] = '{mask: 4'b0101, n: 3'd2, ord: {2'd0, 2'd0, 2'd0, 2'd2}};

    for (int k = 0; k < NM; k++) begin
      m_adr_i[k*WB_AW +: WB_AW] = adr_of(k);
      m_dat_i[k*WB_DW +: WB_DW] = 32'h1111_0000 + 32'(k);
    end
    m_sel_i = '1;
    m_cti_i = '0;
    m_we_i  = '0;
    m_cyc_i = '0;
    m_stb_i = '0;
    s_dat_i = '0;
    s_ack_i = 1'b0;
    sys_rst = 1'b1;
    #2 sys_rst = 1'b0;
    #2;
    check("rst_grant", 32'(grant_o), 32'd0);
    check("rst_cyc",   32'(s_cyc_o), 32'd0);
    check("rst_ack",   32'(m_ack_o), 32'd0);
    repeat (3) step();
    sys_rst = 1'b1;
    step();

    // Reset in the middle of an m1 burst kills everything in the same cycle.
    exp_q.push_back(1);
    m_cyc_i = 4'b0010;
    m_stb_i = 4'b0010;
    m_cti_i[1*WB_CW +: WB_CW] = CTI_INCR;
    await_grant("t1_grant", 1);
    s_ack_i = 1'b1;
    #1;
    check("t1_ack_beat0", 32'(m_ack_o), 32'h2);
    step();
    check("t1_cyc_before", 32'(s_cyc_o), 32'd1);
    #2 sys_rst = 1'b0;
    #1;
    check("t1_cyc_rst",   32'(s_cyc_o), 32'd0);
    check("t1_stb_rst",   32'(s_stb_o), 32'd0);
    check("t1_ack_rst",   32'(m_ack_o), 32'd0);
    check("t1_grant_rst", 32'(grant_o), 32'd0);
    s_ack_i = 1'b0;
    m_cyc_i = '0;
    m_stb_i = '0;
    m_cti_i = '0;
    step();
    sys_rst = 1'b1;
    step();

    // Rotation table; the first entry also proves master 0 wins after reset.
    for (int i = 0; i < 7; i++) run_vec(vt[i]);

    // Spurious slave ack while idle must not reach any master.
    s_ack_i = 1'b1;
    #1;
    check("t6_ack_idle",   32'(m_ack_o), 32'd0);
    check("t6_grant_idle", 32'(grant_o), 32'd0);
    step();
    s_ack_i = 1'b0;
    check("t6_grant_after", 32'(grant_o), 32'd0);

    // m1 four-beat burst with m2 waiting; m2 gets the bus 2 cycles after m1 drops.
    exp_q.push_back(1);
    exp_q.push_back(2);
    m_cyc_i = 4'b0110;
    m_stb_i = 4'b0110;
    m_cti_i[1*WB_CW +: WB_CW] = CTI_INCR;
    await_grant("t3_m1", 1);
    for (int b = 0; b < 4; b++) begin
      if (b == 3) begin
        m_cti_i[1*WB_CW +: WB_CW] = CTI_EOB;
        m_cyc_i[1] = 1'b0;
        m_stb_i[1] = 1'b0;
      end
      s_ack_i = 1'b1;
      #1;
      check("t3_burst_ack",   32'(m_ack_o), 32'h2);
      check("t3_burst_grant", 32'(grant_o), 32'h2);
      step();
    end
    s_ack_i = 1'b0;
    m_cti_i = '0;
    check("t3_idle", 32'(grant_o), 32'd0);
    step();
    await_grant("t3_m2", 0);
    s_ack_i = 1'b1;
    m_cyc_i[2] = 1'b0;
    m_stb_i[2] = 1'b0;
    #1;
    check("t3_m2_ack", 32'(m_ack_o), 32'h4);
    step();
    s_ack_i = 1'b0;

    // Watchdog: m2 never acked, err 8 cycles after stb, then drain until release.
    exp_q.push_back(2);
    m_cyc_i[2] = 1'b1;
    m_stb_i[2] = 1'b1;
    first = 0;
    nerr  = 0;
    errv  = '0;
    step();
    await_grant("t4_grant", 0);
    for (int k = 1; k <= 12; k++) begin
      if (k > 1) step();
      if (m_err_o != '0) begin
        nerr++;
        if (first == 0) begin
          first = k;
          errv  = m_err_o;
        end
      end
      if (k == 9) begin
        check("t4_drain_cyc",   32'(s_cyc_o), 32'd0);
        check("t4_drain_grant", 32'(grant_o), 32'h4);
      end
      if (k == 10) begin
        s_ack_i = 1'b1;
        #1;
        check("t4_drain_ack", 32'(m_ack_o), 32'd0);
        s_ack_i = 1'b0;
      end
    end
    check("t4_err_cycle", 32'(first), 32'd8);
    check("t4_err_bits",  32'(errv),  32'h4);
    check("t4_err_count", 32'(nerr),  32'd1);
    m_cyc_i[2] = 1'b0;
    m_stb_i[2] = 1'b0;
    step();
    check("t4_release", 32'(grant_o), 32'd0);

    // Ack in the terminal watchdog cycle wins, and the count restarts from zero.
    exp_q.push_back(3);
    m_cyc_i[3] = 1'b1;
    m_stb_i[3] = 1'b1;
    nerr = 0;
    step();
    await_grant("t5_grant", 0);
    for (int k = 2; k <= 7; k++) begin
      step();
      if (m_err_o != '0) nerr++;
    end
    step();
    s_ack_i = 1'b1;
    #1;
    check("t5_ack",   32'(m_ack_o), 32'h8);
    check("t5_noerr", 32'(m_err_o), 32'd0);
    for (int k = 9; k <= 16; k++) begin
      step();
      s_ack_i = 1'b0;
      #1;
      if (k == 9) check("t5_still_cyc", 32'(s_cyc_o), 32'd1);
      if (k < 16) begin
        if (m_err_o != '0) nerr++;
      end else begin
        check("t5_err_restart", 32'(m_err_o), 32'h8);
      end
    end
    check("t5_no_early_err", 32'(nerr), 32'd0);
    m_cyc_i[3] = 1'b0;
    m_stb_i[3] = 1'b0;
    step();
    check("t5_release", 32'(grant_o), 32'd0);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
